// File: rtl/alu_sched_pkg.sv
// Shared types and defaults for the alu_sched operation scheduler.
// Holds the opcode and FSM state encodings plus the default datapath width.
package alu_sched_pkg;

    localparam int WIDTH_DEFAULT = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_SUB = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_sched_div.sv
// Iterative restoring divider for alu_sched, built only with ALU_SCHED_DIV_EN.
// The first quotient bit is resolved on the start edge, so WIDTH edges yield the result.
module alu_sched_div #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [WIDTH-1:0] step_rem, step_quo, step_dvs;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] next_rem, next_quo;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        step_rem = start_i ? '0         : rem_q;
        step_quo = start_i ? dividend_i : quo_q;
        step_dvs = start_i ? divisor_i  : dvs_q;
        trial    = {step_rem, step_quo[WIDTH-1]} - {1'b0, step_dvs};
        if (trial[WIDTH]) begin
            next_rem = {step_rem[WIDTH-2:0], step_quo[WIDTH-1]};
            next_quo = {step_quo[WIDTH-2:0], 1'b0};
        end else begin
            next_rem = trial[WIDTH-1:0];
            next_quo = {step_quo[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        // NOTE: every next-state signal takes its current value first, so no path leaves it unassigned and no latch is inferred.
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i) begin
            rem_d  = next_rem;
            quo_d  = next_quo;
            dvs_d  = divisor_i;
            cnt_d  = CW'(WIDTH - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = next_rem;
            quo_d = next_quo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/alu_sched.sv
// Two-requester round-robin ALU scheduler with a single registered response slot.
// Define ALU_SCHED_DIV_EN to build the iterative divider; otherwise div reports an error.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [1:0]       req0_op,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_flag,
    output logic             rsp_err
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic             rr_q, rr_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             rsp_id_q, rsp_id_d, rsp_flag_q, rsp_flag_d, rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;

    logic             grant, grant_id;
    op_e              g_op;
    logic [WIDTH-1:0] g_a, g_b;

    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   exec_result;
    logic               exec_flag, exec_err, exec_done;

    // With both requesters valid the pointer decides; a lone requester always wins.
    assign grant      = (state_q == ST_IDLE) && (req0_valid || req1_valid);
    assign grant_id   = (req0_valid && req1_valid) ? rr_q : req1_valid;
    assign req0_ready = grant && !grant_id;
    assign req1_ready = grant && grant_id;

    assign g_op = op_e'(grant_id ? req1_op : req0_op);
    assign g_a  = grant_id ? req1_a : req0_a;
    assign g_b  = grant_id ? req1_b : req0_b;

`ifdef ALU_SCHED_DIV_EN
    logic             div_start, div_busy, div_done;
    logic [WIDTH-1:0] div_quotient;

    assign div_start = grant && (g_op == OP_DIV) && (g_b != '0);

    alu_sched_div #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (g_a),
        .divisor_i  (g_b),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quotient)
    );
`endif

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};
    assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    always_comb begin
        exec_result = '0;
        exec_flag   = 1'b0;
        exec_err    = 1'b0;
        exec_done   = 1'b1;
        case (op_q)
            OP_ADD: begin
                exec_result = sum[WIDTH-1:0];
                exec_flag   = sum[WIDTH];
            end
            OP_SUB: begin
                exec_result = diff[WIDTH-1:0];
                exec_flag   = diff[WIDTH];
            end
            OP_MUL: begin
                exec_result = prod[WIDTH-1:0];
                exec_flag   = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
`ifdef ALU_SCHED_DIV_EN
                if (b_q == '0) begin
                    exec_err = 1'b1;
                end else if (div_done) begin
                    exec_result = div_quotient;
                end else if (div_busy) begin
                    exec_done = 1'b0;
                end else begin
                    // Divider idle without a result: report an error rather than hang in EXEC.
                    exec_err = 1'b1;
                end
`else
                exec_err = 1'b1;
`endif
            end
            default: exec_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flag_d   = rsp_flag_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    op_d    = g_op;
                    a_d     = g_a;
                    b_d     = g_b;
                    id_d    = grant_id;
                    rr_d    = !grant_id;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    rsp_id_d     = id_q;
                    rsp_result_d = exec_result;
                    rsp_flag_d   = exec_flag;
                    rsp_err_d    = exec_err;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flag_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flag_q   <= rsp_flag_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flag   = rsp_flag_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched at WIDTH=2: literal vectors, arbitration and
// reset sequences, then random operations against an arithmetic reference model.
module tb_alu_sched;

    localparam int W   = 2;
    localparam int ADD = 0;
    localparam int MUL = 1;
    localparam int SUB = 2;
    localparam int DIV = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_flag, rsp_err;
    logic [W-1:0] rsp_result;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int id;
        int op;
        int a;
        int b;
        int res;
        int flag;
        int err;
        int lat;
    } vec_t;

    vec_t vecs[$];

    alu_sched #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flag   (rsp_flag),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit expired");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int id, input int op, input int a, input int b,
                                input int res, input int flag, input int err, input int lat);
        vec_t v;
        v.id = id; v.op = op; v.a = a; v.b = b;
        v.res = res; v.flag = flag; v.err = err; v.lat = lat;
        return v;
    endfunction

    // Reference behaviour from the arithmetic definitions, latency in cycles after the accept cycle.
    task automatic model(input int op, input int a, input int b,
                         output int res, output int flag, output int err, output int lat);
        int m;
        m    = 1 << W;
        res  = 0;
        flag = 0;
        err  = 0;
        lat  = 2;
        case (op)
            ADD: begin res = (a + b) % m;     flag = (a + b >= m) ? 1 : 0; end
            MUL: begin res = (a * b) % m;     flag = (a * b >= m) ? 1 : 0; end
            SUB: begin res = (a - b + m) % m; flag = (a < b) ? 1 : 0;      end
            default: begin
`ifdef ALU_SCHED_DIV_EN
                if (b == 0) err = 1;
                else begin
                    res = a / b;
                    lat = 1 + W;
                end
`else
                err = 1;
`endif
            end
        endcase
    endtask

    task automatic drive(input int id, input bit v, input int op, input int a, input int b);
        if (id == 0) begin
            req0_valid = v; req0_op = op[1:0]; req0_a = a[W-1:0]; req0_b = b[W-1:0];
        end else begin
            req1_valid = v; req1_op = op[1:0]; req1_a = a[W-1:0]; req1_b = b[W-1:0];
        end
    endtask

    function automatic int ready_bits();
        return int'({req1_ready, req0_ready});
    endfunction

    task automatic wait_rsp(output int k);
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!rsp_valid && k < 40);
    endtask

    // One operation: accept, noise on all request inputs while busy, then check the response.
    task automatic run_op(input string name, input int id, input int op, input int a, input int b,
                          input int res, input int flag, input int err, input int lat);
        int k;
        bit stray;
        @(negedge clk);
        rsp_ready = 1'b1;
        drive(id, 1'b1, op, a, b);
        drive(1 - id, 1'b0, 0, 0, 0);
        #1;
        check({name, "_grant"}, ready_bits(), (id == 1) ? 2 : 1);
        k = 0;
        stray = 1'b0;
        do begin
            @(negedge clk);
            drive(0, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            drive(1, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            #1;
            k++;
            if (req0_ready || req1_ready) stray = 1'b1;
        end while (!rsp_valid && k < 40);
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        check({name, "_latency"}, k, lat);
        check({name, "_id"}, int'(rsp_id), id);
        check({name, "_result"}, int'(rsp_result), res);
        check({name, "_flag"}, int'(rsp_flag), flag);
        check({name, "_err"}, int'(rsp_err), err);
        check({name, "_busy_ready"}, int'(stray), 0);
    endtask

    initial begin
        int k;
        bit bad;

        vecs.push_back(mk(0, ADD, 3, 2, 1, 1, 0, 2));
        vecs.push_back(mk(1, SUB, 1, 2, 3, 1, 0, 2));
        vecs.push_back(mk(1, MUL, 3, 3, 1, 1, 0, 2));
        vecs.push_back(mk(0, ADD, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, ADD, 3, 3, 2, 1, 0, 2));
        vecs.push_back(mk(1, SUB, 3, 3, 0, 0, 0, 2));
        vecs.push_back(mk(0, SUB, 0, 3, 1, 1, 0, 2));
        vecs.push_back(mk(1, MUL, 2, 2, 0, 1, 0, 2));
        vecs.push_back(mk(0, MUL, 3, 1, 3, 0, 0, 2));
`ifdef ALU_SCHED_DIV_EN
        vecs.push_back(mk(0, DIV, 3, 2, 1, 0, 0, 3));
        vecs.push_back(mk(1, DIV, 2, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, DIV, 3, 3, 1, 0, 0, 3));
        vecs.push_back(mk(1, DIV, 1, 3, 0, 0, 0, 3));
        vecs.push_back(mk(0, DIV, 3, 1, 3, 0, 0, 3));
`else
        vecs.push_back(mk(0, DIV, 3, 1, 0, 0, 1, 2));
        vecs.push_back(mk(1, DIV, 2, 0, 0, 0, 1, 2));
`endif

        rst       = 1'b1;
        rsp_ready = 1'b0;
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        #7;
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_id", int'(rsp_id), 0);
        check("reset_rsp_result", int'(rsp_result), 0);
        check("reset_rsp_flag", int'(rsp_flag), 0);
        check("reset_rsp_err", int'(rsp_err), 0);
        check("reset_ready", ready_bits(), 0);

        // Both requesters held valid straight out of reset: grants must alternate 0,1,0,1.
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, ADD, 1, 2);
        drive(1, 1'b1, SUB, 0, 1);
        for (int g = 0; g < 4; g++) begin
            int eid, er, ef, ee, el;
            eid = g % 2;
            if (eid == 0) model(ADD, 1, 2, er, ef, ee, el);
            else          model(SUB, 0, 1, er, ef, ee, el);
            if (g > 0) @(negedge clk);
            #1;
            check("rr_grant", ready_bits(), (eid == 1) ? 2 : 1);
            wait_rsp(k);
            check("rr_latency", k, el);
            check("rr_id", int'(rsp_id), eid);
            check("rr_result", int'(rsp_result), er);
            check("rr_flag", int'(rsp_flag), ef);
            if (g == 0) begin
                bad = 1'b0;
                for (int h = 0; h < 4; h++) begin
                    @(negedge clk);
                    #1;
                    if (!rsp_valid || int'(rsp_result) != er || int'(rsp_id) != eid ||
                        int'(rsp_flag) != ef || req0_ready || req1_ready) bad = 1'b1;
                end
                check("rr_hold_stable", int'(bad), 0);
                rsp_ready = 1'b1;
            end
            check("rr_consume_no_accept", ready_bits(), 0);
            if (g == 3) begin
                drive(0, 1'b0, 0, 0, 0);
                drive(1, 1'b0, 0, 0, 0);
            end
        end

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].flag, vecs[i].err, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            int id, op, a, b, er, ef, ee, el;
            id = $urandom_range(0, 1);
            op = $urandom_range(0, 3);
            a  = $urandom_range(0, 3);
            b  = $urandom_range(0, 3);
            model(op, a, b, er, ef, ee, el);
            run_op($sformatf("rand%0d", i), id, op, a, b, er, ef, ee, el);
        end

        // Reset while a response waits unconsumed.
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1, 1'b1, ADD, 3, 2);
        drive(0, 1'b0, 0, 0, 0);
        #1;
        check("rstr_grant", ready_bits(), 2);
        wait_rsp(k);
        check("rstr_latency", k, 2);
        drive(1, 1'b0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("rstr_rsp_valid", int'(rsp_valid), 0);
        check("rstr_rsp_id", int'(rsp_id), 0);
        check("rstr_rsp_result", int'(rsp_result), 0);
        check("rstr_rsp_flag", int'(rsp_flag), 0);
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (rsp_valid) bad = 1'b1;
        end
        check("rstr_no_stale", int'(bad), 0);

        // Reset in the middle of a division; the pointer must return to requester 0.
        @(negedge clk);
        drive(0, 1'b1, DIV, 3, 1);
        #1;
        check("rstd_grant", ready_bits(), 1);
        @(negedge clk);
        drive(0, 1'b0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("rstd_rsp_valid", int'(rsp_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (rsp_valid) bad = 1'b1;
        end
        check("rstd_no_stale", int'(bad), 0);
        drive(0, 1'b1, ADD, 2, 1);
        drive(1, 1'b1, SUB, 2, 1);
        #1;
        check("rstd_rr_grant", ready_bits(), 1);
        wait_rsp(k);
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        check("rstd_latency", k, 2);
        check("rstd_id", int'(rsp_id), 0);
        check("rstd_result", int'(rsp_result), 3);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
